seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer.sv | 130 +++++++++++++
 tb/tb_seq_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial converter with a one-word holding buffer.
// Words are accepted into the holding buffer, then transferred into a shift
// register and emitted one bit per enabled cycle. Back-to-back words stream
// gaplessly when the next word is already held at the last bit of the current one.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sh_reg, sh_next;
    logic [WIDTH-1:0]   hold_reg, hold_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               hold_full_reg, hold_full_next;

    logic               accept;
    logic               transfer;
    logic               last_bit;
    logic [WIDTH-1:0]   sh_shifted;
    logic               out_bit;

    // Acceptance only ever happens with an empty buffer, so it can never
    // coincide with a hold-to-shift transfer (which needs a full buffer).
    assign accept   = din_valid & ~hold_full_reg;
    assign last_bit = (cnt_reg == CNT_LAST);

    // Bit order only changes which end of sh feeds dout and the shift direction.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign sh_shifted = {sh_reg[WIDTH-2:0], 1'b0};
            assign out_bit    = sh_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign sh_shifted = {1'b0, sh_reg[WIDTH-1:1]};
            assign out_bit    = sh_reg[0];
        end
    endgenerate

    // Shift engine next-state: load from hold, shift, stall, or return to idle.
    always_comb begin
        state_next = state_reg;
        sh_next    = sh_reg;
        cnt_next   = cnt_reg;
        transfer   = 1'b0;
        case (state_reg)
            IDLE: begin
                // The idle load ignores en; only shifting is stalled by it.
                if (hold_full_reg) begin
                    transfer   = 1'b1;
                    sh_next    = hold_reg;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (!last_bit) begin
                        sh_next  = sh_shifted;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else if (hold_full_reg) begin
                        transfer = 1'b1;
                        sh_next  = hold_reg;
                        cnt_next = '0;
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Holding buffer next-state: a transfer empties it, an acceptance fills it.
    always_comb begin
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        if (transfer) begin
            hold_full_next = 1'b0;
        end else if (accept) begin
            hold_full_next = 1'b1;
            hold_next      = din;
        end
    end

    // State register; reset discards both the partial word and any held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            sh_reg        <= '0;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sh_reg        <= sh_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
        end
    end

    assign din_ready   = ~hold_full_reg;
    assign dout        = (state_reg == SHIFT) ? out_bit : 1'b0;
    assign dout_valid  = (state_reg == SHIFT) & en;
    assign frame_start = dout_valid & (cnt_reg == '0);
    assign busy        = (state_reg == SHIFT) | hold_full_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// Testbench for seq_serializer: two instances (MSB-first and LSB-first) share
// the same stimulus; a queue-based bit-stream model predicts every output.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         en = 1'b0;

    logic m_dout, m_dv, m_fs, m_busy, m_ready;
    logic l_dout, l_dv, l_fs, l_busy, l_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
        .en(en), .dout(m_dout), .dout_valid(m_dv), .frame_start(m_fs), .busy(m_busy)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
        .en(en), .dout(l_dout), .dout_valid(l_dv), .frame_start(l_fs), .busy(l_busy)
    );

    // ---------------- reference model: pending bit streams + held word ----------
    bit           mq_m[$];
    bit           mq_l[$];
    bit           held_v = 1'b0;
    logic [W-1:0] held_w = '0;

    function automatic void model_reset();
        mq_m.delete();
        mq_l.delete();
        held_v = 1'b0;
        held_w = '0;
    endfunction

    function automatic void model_load(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) mq_m.push_back(w[i]);
        for (int i = 0; i < W; i++) mq_l.push_back(w[i]);
    endfunction

    // Applied once per rising edge with the inputs that were present before it.
    function automatic void model_edge();
        bit acc;
        acc = din_valid && !held_v;
        if (mq_m.size() > 0 && en) begin
            void'(mq_m.pop_front());
            void'(mq_l.pop_front());
        end
        if (mq_m.size() == 0 && held_v) begin
            model_load(held_w);
            held_v = 1'b0;
        end
        if (acc) begin
            held_w = din;
            held_v = 1'b1;
            $display("[%0t] accept word %h", $time, din);
        end
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        bit act_w, em, el;
        act_w = (mq_m.size() > 0);
        em = 1'b0;
        el = 1'b0;
        if (act_w) begin
            em = mq_m[0];
            el = mq_l[0];
        end
        chk({tag, ".dout_m"}, m_dout, em);
        chk({tag, ".dout_l"}, l_dout, el);
        chk({tag, ".dv_m"}, m_dv, act_w && en);
        chk({tag, ".dv_l"}, l_dv, act_w && en);
        chk({tag, ".fs_m"}, m_fs, act_w && en && (mq_m.size() == W));
        chk({tag, ".fs_l"}, l_fs, act_w && en && (mq_l.size() == W));
        chk({tag, ".rdy_m"}, m_ready, !held_v);
        chk({tag, ".rdy_l"}, l_ready, !held_v);
        chk({tag, ".busy_m"}, m_busy, act_w || held_v);
        chk({tag, ".busy_l"}, l_busy, act_w || held_v);
    endtask

    task automatic apply(input logic [W-1:0] d, input logic v, input logic e);
        din       = d;
        din_valid = v;
        en        = e;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    // ---------------- multi-cycle collection helper ------------------------------
    logic [W-1:0] pend[$];
    bit           en_pat[$];
    bit           got_m[$];
    bit           got_l[$];
    int           dv_cyc[$];
    int           fs_cyc[$];

    task automatic run_collect(input string tag, input int ncyc);
        bit e, v;
        got_m.delete(); got_l.delete(); dv_cyc.delete(); fs_cyc.delete();
        for (int i = 0; i < ncyc; i++) begin
            e = (i < en_pat.size()) ? en_pat[i] : 1'b1;
            v = (pend.size() > 0);
            apply(v ? pend[0] : '0, v, e);
            check_model(tag);
            if (m_dv) begin
                got_m.push_back(m_dout);
                got_l.push_back(l_dout);
                dv_cyc.push_back(i);
            end
            if (m_fs) fs_cyc.push_back(i);
            if (v && m_ready) void'(pend.pop_front());
            advance();
        end
    endtask

    // ---------------- directed table ----------------------------------------------
    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         e;
        logic         dm;
        logic         dl;
        logic         dv;
        logic         fs;
        logic         rdy;
        logic         bsy;
    } vec_t;

    vec_t tbl[22];

    logic [15:0] b2b_word;
    logic [W-1:0] w_a5;

    initial begin
        //            din    v     e     dm    dl    dv    fs    rdy   bsy
        tbl[0]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[19] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[20] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[21] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // ---- reset state ----
        model_reset();
        #2;
        check_model("reset");
        @(negedge clk);
        check_model("reset_hold");
        rst = 1'b1;

        // ---- table: A5 then 01, both bit orders ----
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].d, tbl[i].v, tbl[i].e);
            chk($sformatf("tbl%0d.dout_m", i), m_dout, tbl[i].dm);
            chk($sformatf("tbl%0d.dout_l", i), l_dout, tbl[i].dl);
            chk($sformatf("tbl%0d.dv", i), m_dv, tbl[i].dv);
            chk($sformatf("tbl%0d.fs", i), m_fs, tbl[i].fs);
            chk($sformatf("tbl%0d.rdy", i), m_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d.busy", i), m_busy, tbl[i].bsy);
            check_model("tbl");
            advance();
        end

        // ---- back-to-back 05 then FF, din_valid held while the buffer is full ----
        pend = '{8'h05, 8'hFF};
        en_pat.delete();
        run_collect("b2b", 22);
        b2b_word = 16'h05FF;
        chk("b2b.count16", got_m.size() == 16, 1'b1);
        if (got_m.size() == 16) begin
            for (int i = 0; i < 16; i++)
                chk($sformatf("b2b.bit%0d", i), got_m[i], b2b_word[15-i]);
            chk("b2b.contiguous", (dv_cyc[15] - dv_cyc[0]) == 15, 1'b1);
        end
        chk("b2b.fs_count", fs_cyc.size() == 2, 1'b1);
        if (fs_cyc.size() == 2) chk("b2b.fs_spacing", (fs_cyc[1] - fs_cyc[0]) == 8, 1'b1);

        // ---- stall: en low for three cycles after the third bit of A5 ----
        pend = '{8'hA5};
        en_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_collect("stall", 16);
        en_pat.delete();
        w_a5 = 8'hA5;
        chk("stall.count8", got_m.size() == 8, 1'b1);
        if (got_m.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("stall.m%0d", i), got_m[i], w_a5[7-i]);
                chk($sformatf("stall.l%0d", i), got_l[i], w_a5[i]);
            end
            chk("stall.gap", (dv_cyc[3] - dv_cyc[2]) == 4, 1'b1);
        end

        // ---- asynchronous reset during bit 5 of 3C with 81 held ----
        apply(8'h3C, 1'b1, 1'b1); check_model("rst_seq"); advance();   // accept 3C
        apply(8'h81, 1'b1, 1'b1); check_model("rst_seq"); advance();   // ignored, transfer
        apply(8'h81, 1'b1, 1'b1); check_model("rst_seq"); advance();   // bit1, accept 81
        for (int i = 0; i < 3; i++) begin
            apply(8'h00, 1'b0, 1'b1); check_model("rst_seq"); advance(); // bits 2..4
        end
        apply(8'h00, 1'b0, 1'b1);
        check_model("rst_bit5");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst.dout_m", m_dout, 1'b0);
        chk("arst.dout_l", l_dout, 1'b0);
        chk("arst.dv", m_dv, 1'b0);
        chk("arst.fs", m_fs, 1'b0);
        chk("arst.busy", m_busy, 1'b0);
        chk("arst.rdy", m_ready, 1'b1);
        advance();
        check_model("rst_low");
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply(8'h00, 1'b0, 1'b1);
            check_model("post_rst");
            advance();
        end

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 1500; i++) begin
            apply(W'($urandom), ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 80));
            check_model("rand");
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
